// File: rtl/mem_req_sequencer.sv
// In-order request front-end for the mem16x32 memory: buffers write/read requests,
// issues them one at a time and returns read data over a valid/ready channel.
module mem_req_sequencer #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                fifo_wr_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   op_addr_q;
  logic [DATA_W-1:0]   op_data_q;
  logic [ADDR_W-1:0]   rsp_addr_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q;
  logic                push, pop, cap_rsp, wr_inc, rd_inc;

  // req_ready depends on registered fill only, so a same-cycle pop never frees a slot early.
  assign req_ready = (fill_q != FULL_FILL);
  assign push      = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    cap_rsp = 1'b0;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_wr_q) begin
          wr_inc  = 1'b1;
          state_d = S_IDLE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          cap_rsp = 1'b1;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rd_inc  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push && pop) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wptr_q]   <= req_wr;
      fifo_addr_q[wptr_q] <= req_addr;
      fifo_data_q[wptr_q] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      lat_q      <= '0;
      op_wr_q    <= 1'b0;
      op_addr_q  <= '0;
      op_data_q  <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      fill_q  <= fill_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q    <= rptr_q + 1'b1;
        op_wr_q   <= fifo_wr_q[rptr_q];
        op_addr_q <= fifo_addr_q[rptr_q];
        op_data_q <= fifo_data_q[rptr_q];
      end
      if (cap_rsp) begin
        rsp_data_q <= mem_dout;
        rsp_addr_q <= op_addr_q;
      end
      if (wr_inc && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      if (rd_inc && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

  // Memory address/data come straight from the op register, which only changes on pop,
  // so they hold their last values outside ISSUE.
  assign mem_en    = (state_q == S_ISSUE);
  assign mem_wr    = (state_q == S_ISSUE) && op_wr_q;
  assign mem_addr  = op_addr_q;
  assign mem_din   = op_data_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign busy      = (fill_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Randomized bench for mem_req_sequencer: an in-order transaction model (queues + shadow
// memory) is compared against the DUT on every negedge, plus directed literal checks.
module tb_mem_req_sequencer;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready, rsp_valid, mem_en, mem_wr, busy;
  logic          rsp_ready = 1'b1;
  logic [AW-1:0] rsp_addr, mem_addr;
  logic [DW-1:0] rsp_data, mem_din;
  logic [DW-1:0] mem_dout;
  logic [15:0]   wr_cnt, rd_cnt;

  logic          s_req_valid = 1'b0;
  logic          s_req_ready, s_rsp_valid, s_mem_en, s_mem_wr, s_busy;
  logic [AW-1:0] s_rsp_addr, s_mem_addr;
  logic [DW-1:0] s_rsp_data, s_mem_din;
  logic [3:0]    s_wr_cnt, s_rd_cnt;

  mem_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .busy(busy)
  );

  mem_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wr(1'b1), .req_addr(4'd7), .req_data(32'hA5A5A5A5),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_addr(s_rsp_addr), .rsp_data(s_rsp_data),
    .mem_en(s_mem_en), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_din(s_mem_din), .mem_dout(32'h0),
    .wr_cnt(s_wr_cnt), .rd_cnt(s_rd_cnt), .busy(s_busy)
  );

  // Environment memory (mem16x32 behaviour, one-cycle read latency).
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_en && mem_wr) mem[mem_addr] <= mem_din;
    if (mem_en && !mem_wr) mem_dout <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t           opq[$];
  op_t           rspq[$];
  logic [DW-1:0] shadow [16];
  int unsigned   accepted, issued, rd_issued, rd_hs, wr_done, s_wr_done;
  int            cyc = 0;
  int            rd_issue_cyc = 0;

  always @(negedge clk) begin
    op_t         o;
    logic        exp_wr, exp_rv, can_push;
    int unsigned occ;
    cyc++;
    if (!rst_n) begin
      opq.delete();
      rspq.delete();
      accepted = 0; issued = 0; rd_issued = 0; rd_hs = 0; wr_done = 0; s_wr_done = 0;
      for (int i = 0; i < 16; i++) shadow[i] = mem[i];
      if (mem_en && mem_wr) shadow[mem_addr] = mem_din;
    end else begin
      exp_wr = mem_wr;
      if (mem_en) begin
        chk("issue_with_read_open", 64'(rd_issued - rd_hs), 64'd0);
        if (opq.size() == 0) begin
          chk("mem_en_unexpected", {63'd0, mem_en}, 64'd0);
        end else begin
          o = opq.pop_front();
          exp_wr = o.wr;
          chk("mem_wr", {63'd0, mem_wr}, {63'd0, o.wr});
          chk("mem_addr", 64'(mem_addr), 64'(o.addr));
          if (o.wr) chk("mem_din", 64'(mem_din), 64'(o.data));
        end
        issued++;
        if (!exp_wr) begin
          rd_issued++;
          rd_issue_cyc = cyc;
        end
      end
      occ = accepted - issued;
      can_push = (occ != DEPTH);
      chk("req_ready", {63'd0, req_ready}, {63'd0, can_push});
      chk("busy", {63'd0, busy}, {63'd0, (occ != 0) || mem_en || (rd_issued != rd_hs)});
      chk("wr_cnt", 64'(wr_cnt), 64'(wr_done));
      chk("rd_cnt", 64'(rd_cnt), 64'(rd_hs));
      exp_rv = (rd_issued != rd_hs) && (cyc >= rd_issue_cyc + int'(LAT) + 1);
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_rv});
      if (exp_rv && rspq.size() != 0) begin
        chk("rsp_addr", 64'(rsp_addr), 64'(rspq[0].addr));
        chk("rsp_data", 64'(rsp_data), 64'(rspq[0].data));
        if (rsp_ready) begin
          void'(rspq.pop_front());
          rd_hs++;
        end
      end
      if (mem_en && exp_wr) wr_done++;
      if (req_valid && can_push) begin
        o.wr = req_wr; o.addr = req_addr; o.data = req_data;
        opq.push_back(o);
        if (req_wr) begin
          shadow[req_addr] = req_data;
        end else begin
          o.data = shadow[req_addr];
          rspq.push_back(o);
        end
        accepted++;
      end
      chk("sat_wr_cnt", 64'(s_wr_cnt), (s_wr_done > 15) ? 64'd15 : 64'(s_wr_done));
      if (s_mem_en && s_mem_wr) s_wr_done++;
    end
  end

  // ---------------- stimulus ----------------
  logic rsp_rand = 1'b0;
  logic rsp_hold = 1'b1;
  always @(posedge clk) begin
    #2;
    rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_hold;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = !busy && (opq.size() == 0) && (rspq.size() == 0);
    end
    chk("drain", {63'd0, done}, 64'd1);
    tick();
  endtask

  initial begin
    int k;
    logic [AW-1:0] a0;
    int n_acc;

    tick();
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    tick();

    // Single write: mem_en two edges after acceptance.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_data = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("w1_no_en_yet", {63'd0, mem_en}, 64'd0);
    tick();
    @(negedge clk);
    chk("w1_mem_en", {63'd0, mem_en}, 64'd1);
    chk("w1_mem_wr", {63'd0, mem_wr}, 64'd1);
    chk("w1_mem_addr", 64'(mem_addr), 64'd3);
    chk("w1_mem_din", 64'(mem_din), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("w1_wr_cnt", 64'(wr_cnt), 64'd1);
    chk("w1_addr_hold", 64'(mem_addr), 64'd3);
    tick();

    // Write then read back to back.
    rsp_hold = 1'b1;
    send(1'b1, 4'd5, 32'h12345678);
    send(1'b0, 4'd5, 32'h0);
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("rd_latency", 64'(k), 64'd4);
    chk("rd_rsp_addr", 64'(rsp_addr), 64'd5);
    chk("rd_rsp_data", 64'(rsp_data), 64'h12345678);
    tick();
    @(negedge clk);
    chk("rd_rd_cnt", 64'(rd_cnt), 64'd1);
    drain();

    // Consumer stall with producer pushing continuously.
    rsp_hold = 1'b0;
    a0 = 4'd3;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      k++;
      tick();
      req_addr = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
    end
    chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
    chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("stall_rsp_addr", 64'(rsp_addr), 64'(a0));
    chk("stall_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("stall_fill", 64'(accepted - issued), 64'(DEPTH));
    tick();
    req_valid = 1'b0;
    rsp_hold = 1'b1;
    drain();

    // Burst: 16 writes then 16 reads, random consumer backpressure.
    do_reset();
    rsp_rand = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 32'h0);
    drain();
    rsp_rand = 1'b0;
    @(negedge clk);
    chk("burst_wr_cnt", 64'(wr_cnt), 64'd16);
    chk("burst_rd_cnt", 64'(rd_cnt), 64'd16);
    chk("burst_busy", {63'd0, busy}, 64'd0);
    chk("burst_last_data", 64'(mem[15]), 64'h0F0F0F0F);
    tick();

    // Reset while a read is in WAIT_RD with two requests queued.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd1;
    tick();
    req_addr = 4'd2;
    tick();
    req_addr = 4'd3;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rstmid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 8; i++) tick();

    // Random traffic.
    rsp_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      tick();
    end
    req_valid = 1'b0;
    drain();
    rsp_rand = 1'b0;

    // Saturation on the CNT_W=4 instance.
    n_acc = 0;
    s_req_valid = 1'b1;
    for (int i = 0; i < 300 && n_acc < 20; i++) begin
      @(negedge clk);
      if (s_req_ready) n_acc++;
      tick();
      if (n_acc == 20) s_req_valid = 1'b0;
    end
    s_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("sat_final", 64'(s_wr_cnt), 64'd15);
    chk("sat_busy", {63'd0, s_busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_req_sequencer.md
Name: mem_req_sequencer

Overview:
- Request front-end that sits directly upstream of the mem16x32 memory.
- Accepts write/read requests over a valid/ready handshake and buffers them in a small in-order FIFO.
- Issues each request to the memory port one at a time.
- Returns read data over a valid/ready response channel and keeps saturating write/read transaction counters for the environment's report.

Parameters:
ADDR_W, 4, memory address width (16 words)
DATA_W, 32, data width
FIFO_DEPTH, 4, request buffer entries (power of two, >=2)
RD_LAT, 1, memory read latency in cycles from mem_en to valid mem_dout (>=1)
CNT_W, 16, width of transaction counters

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request buffer can accept
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_data  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer accepts response
rsp_addr  out  ADDR_W  address of returned read
rsp_data  out  DATA_W  read data
mem_en  out  1  memory access strobe, one cycle per op
mem_wr  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data
wr_cnt  out  CNT_W  completed writes, saturating
rd_cnt  out  CNT_W  completed (handed-off) reads, saturating
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst_n=0 at rising edge):
  - FIFO flushed (pointers and count = 0); FSM to IDLE.
  - All outputs 0 except req_ready=1 from the first cycle after reset.
  - Applies mid-operation: an in-flight read is dropped with no response, and mem_en is 0 the cycle after reset.
- Request side:
  - req_ready = (fifo_count != FIFO_DEPTH), driven from registered state only.
  - Push on req_valid && req_ready.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - A full FIFO stalls the producer. A pop in the same cycle does not raise req_ready that cycle (no pass-through).
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
  - IDLE: if FIFO non-empty, pop head into an op register -> ISSUE; else stay.
  - ISSUE: mem_en=1, mem_wr=op.wr, mem_addr=op.addr, mem_din=op.data for exactly one cycle.
    - Write: wr_cnt++ (saturate at all-ones) -> IDLE.
    - Read: load wait counter = RD_LAT -> WAIT_RD.
  - WAIT_RD: decrement the counter each cycle. In the cycle it reaches 1, register rsp_data<=mem_dout and rsp_addr<=op.addr -> RESP.
  - RESP: rsp_valid=1 with rsp_data and rsp_addr held stable until rsp_ready. On the handshake cycle, rd_cnt++ (saturating) -> IDLE.
  - rsp_valid never drops without a handshake.
- mem_en=0 and mem_wr=0 in every state other than ISSUE. mem_addr and mem_din hold their last values.
- Latency (empty FIFO, RD_LAT=1):
  - Request accepted at edge T. IDLE pops at T+1; ISSUE (mem_en high) during cycle T+2.
  - Reads: mem_dout captured at the end of T+3; rsp_valid high from T+4.
  - Throughput: one write per 2 cycles; one read per 3+RD_LAT cycles plus consumer stall.
- Ordering: strictly in order, including read-after-write to the same address. A read always observes a prior accepted write.
- busy = (fifo_count != 0) || (state != IDLE).

Test Plan:
- Reset, then write addr 3 data 0xDEADBEEF -> mem_en=1 and mem_wr=1 with mem_addr=3 and mem_din=0xDEADBEEF two cycles after acceptance; wr_cnt=1.
- Write addr 5 = 0x12345678, then read addr 5 back to back -> rsp_valid with rsp_addr=5 and rsp_data=0x12345678; rd_cnt=1; order preserved.
- Hold rsp_ready=0 for 10 cycles during a read response, keep req_valid high -> rsp_valid and rsp_data stable throughout; after 4 more requests req_ready=0; no mem_en while in RESP.
- Burst of 16 writes (addr i, data i*0x01010101) then 16 reads, with rsp_ready randomized -> all read data match; wr_cnt=16, rd_cnt=16; busy=0 at the end.
- Assert rst_n=0 for one cycle during WAIT_RD with 2 entries queued -> next cycle mem_en=0, rsp_valid=0, busy=0, req_ready=1; no response emitted for the dropped read.
- Force wr_cnt near saturation (CNT_W=4 build, 20 writes) -> wr_cnt stops at 15.
